ik_joint_update: RTL and testbench

IK_JOINT_UPDATE -- requirements
Module: ik_joint_update

---
 rtl/ik_swift_pkg.sv | 22 ++
 rtl/ik_sat_clamp.sv | 38 +++
 rtl/ik_joint_update.sv | 153 +++++++++++++++
 tb/tb_ik_joint_update.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_swift_pkg.sv
// Shared constants and FSM encoding for the iterative IK joint updater.
// DH parameter slot indices follow the order used on the dh_init/dh_param buses.
package ik_swift_pkg;

    localparam int NJ = 6;
    localparam int W  = 36;

    localparam int THETA = 0;
    localparam int D     = 1;
    localparam int A     = 2;
    localparam int ALPHA = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SOLVE,
        UPDATE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/ik_sat_clamp.sv
// Combinational joint step: saturating two's-complement add, then clamp to limits.
// An inverted limit window (lo > hi) resolves to lo.
module ik_sat_clamp #(
    parameter int W = 36
) (
    input  logic signed [W-1:0] i_sel,
    input  logic signed [W-1:0] i_delta,
    input  logic signed [W-1:0] i_lo,
    input  logic signed [W-1:0] i_hi,
    output logic signed [W-1:0] o_res
);

    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        // Sign bit disagreeing with the guard bit means the true sum left the W-bit range.
        if (s[W] != s[W-1]) begin
            return s[W] ? S_MIN : S_MAX;
        end
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] lo,
                                                  input logic signed [W-1:0] hi);
        if (lo > hi) return lo;
        if (x < lo)  return lo;
        if (x > hi)  return hi;
        return x;
    endfunction

    assign o_res = clamp(sat_add(i_sel, i_delta), i_lo, i_hi);

endmodule

// File: rtl/ik_joint_update.sv
// Iterative IK joint updater: loads DH params, hands them to ik_swift, and applies
// the returned per-joint deltas one joint per cycle until converged or out of budget.
module ik_joint_update
    import ik_swift_pkg::*;
#(
    parameter int NJ = ik_swift_pkg::NJ,
    parameter int W  = ik_swift_pkg::W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NJ-1:0][3:0][W-1:0]     dh_init,
    input  logic [NJ-1:0]                 joint_type,
    input  logic [NJ-1:0][W-1:0]          lim_lo,
    input  logic [NJ-1:0][W-1:0]          lim_hi,
    input  logic signed [W-1:0]           eps,
    input  logic [7:0]                    max_iter,
    output logic                          solve_en,
    input  logic                          solve_done,
    input  logic [NJ-1:0][W-1:0]          delta,
    output logic [NJ-1:0][3:0][W-1:0]     dh_param,
    output logic [7:0]                    iter_count,
    output logic                          busy,
    output logic                          done,
    output logic                          converged
);

    localparam int JW = (NJ > 1) ? $clog2(NJ) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(NJ - 1);
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    state_t                      r_state;
    logic [NJ-1:0][3:0][W-1:0]   r_dh;
    logic [NJ-1:0][W-1:0]        r_delta;
    logic [JW-1:0]               r_j;
    logic                        r_small;
    logic [7:0]                  r_iter;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_conv;
    logic                        r_solve_en;

    logic                        w_prism;
    logic signed [W-1:0]         w_sel;
    logic signed [W-1:0]         w_dlt;
    logic signed [W-1:0]         w_lo;
    logic signed [W-1:0]         w_hi;
    logic signed [W-1:0]         w_upd;
    logic                        w_small_j;
    logic [7:0]                  w_budget;

    // |x| with the most negative value pinned to the largest positive one.
    function automatic logic signed [W-1:0] abs_sat(input logic signed [W-1:0] x);
        if (x == S_MIN) return S_MAX;
        if (x < 0)      return -x;
        return x;
    endfunction

    // One shared step unit, steered to the joint currently being updated.
    assign w_prism   = joint_type[r_j];
    assign w_sel     = w_prism ? r_dh[r_j][D] : r_dh[r_j][THETA];
    assign w_dlt     = r_delta[r_j];
    assign w_lo      = lim_lo[r_j];
    assign w_hi      = lim_hi[r_j];
    assign w_small_j = (abs_sat(w_dlt) < eps);
    assign w_budget  = (max_iter == 8'd0) ? 8'd1 : max_iter;

    ik_sat_clamp #(.W(W)) u_sat_clamp (
        .i_sel   (w_sel),
        .i_delta (w_dlt),
        .i_lo    (w_lo),
        .i_hi    (w_hi),
        .o_res   (w_upd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_dh       <= '0;
            r_delta    <= '0;
            r_j        <= '0;
            r_small    <= 1'b0;
            r_iter     <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_solve_en <= 1'b0;
        end else begin
            r_solve_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_done  <= 1'b0;
                        r_conv  <= 1'b0;
                        r_iter  <= 8'd0;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_dh       <= dh_init;
                    r_state    <= SOLVE;
                    r_solve_en <= 1'b1;
                end
                SOLVE: begin
                    if (solve_done) begin
                        r_delta <= delta;
                        r_j     <= '0;
                        r_small <= 1'b1;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (w_prism) begin
                        r_dh[r_j][D] <= w_upd;
                    end else begin
                        r_dh[r_j][THETA] <= w_upd;
                    end
                    r_small <= r_small & w_small_j;
                    if (r_j == J_LAST) begin
                        r_state <= CHECK;
                        if (r_iter != 8'hFF) begin
                            r_iter <= r_iter + 8'd1;
                        end
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                CHECK: begin
                    if (r_small || (r_iter >= w_budget)) begin
                        r_state <= DONE;
                        r_conv  <= r_small;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= SOLVE;
                        r_solve_en <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dh_param   = r_dh;
    assign iter_count = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;
    assign converged  = r_conv;
    assign solve_en   = r_solve_en;

endmodule

// File: tb/tb_ik_joint_update.sv
// Bench for ik_joint_update: acts as the ik_swift solver and compares against an arithmetic model.
module tb_ik_joint_update;

    localparam int NJ = ik_swift_pkg::NJ;
    localparam int W  = ik_swift_pkg::W;
    localparam int TH = ik_swift_pkg::THETA;
    localparam int DD = ik_swift_pkg::D;
    localparam int AA = ik_swift_pkg::A;
    localparam int AL = ik_swift_pkg::ALPHA;
    localparam longint SMAX = 64'sh7_FFFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [NJ-1:0][3:0][W-1:0] dh_init;
    logic [NJ-1:0]             joint_type;
    logic [NJ-1:0][W-1:0]      lim_lo;
    logic [NJ-1:0][W-1:0]      lim_hi;
    logic signed [W-1:0]       eps;
    logic [7:0]                max_iter;
    logic                      solve_en;
    logic                      solve_done;
    logic [NJ-1:0][W-1:0]      delta;
    logic [NJ-1:0][3:0][W-1:0] dh_param;
    logic [7:0]                iter_count;
    logic                      busy;
    logic                      done;
    logic                      converged;

    ik_joint_update #(.NJ(NJ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dh_init    (dh_init),
        .joint_type (joint_type),
        .lim_lo     (lim_lo),
        .lim_hi     (lim_hi),
        .eps        (eps),
        .max_iter   (max_iter),
        .solve_en   (solve_en),
        .solve_done (solve_done),
        .delta      (delta),
        .dh_param   (dh_param),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: the robot's DH table and solve bookkeeping.
    longint m_dh [NJ][4];
    longint m_lo [NJ];
    longint m_hi [NJ];
    bit     m_jt [NJ];
    longint m_eps;
    int     m_mi;
    int     m_iter;
    bit     m_small;
    longint cur_d [NJ];

    int     g_mode;
    int     g_jnt;
    longint g_dlt;
    longint g_odlt;

    typedef struct {
        int     jnt;
        bit     prism;
        longint sv;
        longint lo;
        longint hi;
        longint dlt;
        longint odlt;
        longint eps;
        int     mi;
        longint exp_val;
        int     exp_iter;
        bit     exp_conv;
        int     exp_pulses;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint step(input longint v, input longint d,
                                    input longint lo, input longint hi);
        longint s;
        s = v + d;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        if (lo > hi) return lo;
        if (s < lo) return lo;
        if (s > hi) return hi;
        return s;
    endfunction

    // Applies one solver answer to the model; returns 1 when the solve should stop.
    function automatic bit model_iter();
        longint a;
        int     k;
        m_small = 1'b1;
        for (int j = 0; j < NJ; j++) begin
            k = m_jt[j] ? DD : TH;
            m_dh[j][k] = step(m_dh[j][k], cur_d[j], m_lo[j], m_hi[j]);
            a = (cur_d[j] < 0) ? -cur_d[j] : cur_d[j];
            if (a > SMAX) a = SMAX;
            if (!(a < m_eps)) m_small = 1'b0;
        end
        m_iter = (m_iter < 255) ? m_iter + 1 : 255;
        return m_small || (m_iter >= ((m_mi == 0) ? 1 : m_mi));
    endfunction

    function automatic void setup_base();
        for (int j = 0; j < NJ; j++) begin
            m_jt[j]     = 1'b0;
            m_dh[j][TH] = 100 * j + 11;
            m_dh[j][DD] = 200 * j + 13;
            m_dh[j][AA] = 300 + j;
            m_dh[j][AL] = -(400 + j);
            m_lo[j]     = -1000000;
            m_hi[j]     = 1000000;
        end
        m_iter = 0;
    endfunction

    task automatic drive_cfg();
        for (int j = 0; j < NJ; j++) begin
            for (int k = 0; k < 4; k++) dh_init[j][k] = W'(m_dh[j][k]);
            joint_type[j] = m_jt[j];
            lim_lo[j]     = W'(m_lo[j]);
            lim_hi[j]     = W'(m_hi[j]);
        end
        eps      = W'(m_eps);
        max_iter = 8'(m_mi);
    endtask

    task automatic gen_delta(input int it);
        longint mag;
        mag = 2000 >>> (2 * it);
        for (int j = 0; j < NJ; j++) begin
            if (g_mode == 1) cur_d[j] = longint'($urandom_range(0, 2 * int'(mag))) - mag;
            else             cur_d[j] = (j == g_jnt) ? g_dlt : g_odlt;
        end
    endtask

    task automatic cmp_dh(input string tag);
        for (int j = 0; j < NJ; j++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_dh[%0d][%0d]", tag, j, k), sx(dh_param[j][k]), m_dh[j][k]);
    endtask

    task automatic run(input bit junk, output int pulses);
        int n;
        int it;
        int k;
        bit fin;
        pulses = 0;
        it     = 0;
        fin    = 1'b0;
        drive_cfg();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk("busy_after_start", busy, 1);
        while (!solve_en && n < 20) begin tick(); n++; end
        chk("start_to_solve_en", n, 2);
        while (!fin && it < 300) begin
            if (!solve_en) begin
                chk("solve_en_present", solve_en, 1);
                break;
            end
            pulses++;
            k = $urandom_range(0, 2);
            if (k > 0) begin
                tick();
                chk("solve_en_width", solve_en, 0);
                for (int i = 1; i < k; i++) tick();
            end
            gen_delta(it);
            for (int j = 0; j < NJ; j++) delta[j] = W'(cur_d[j]);
            solve_done = 1'b1;
            tick();
            solve_done = 1'b0;
            n = 1;
            if (junk) begin
                for (int j = 0; j < NJ; j++) delta[j] = W'($urandom);
                solve_done = 1'b1;
                start      = 1'b1;
                tick();
                solve_done = 1'b0;
                start      = 1'b0;
                n = 2;
            end
            fin = model_iter();
            it++;
            while (!solve_en && !done && n < 100) begin tick(); n++; end
            chk("iter_latency", n, NJ + 2);
            chk("finish_kind", done, fin);
        end
        chk("done_flag", done, 1);
        chk("busy_at_done", busy, 0);
        chk("converged", converged, m_small);
        chk("iter_count", iter_count, m_iter);
        cmp_dh("final");
        // A stray solver handshake after completion must leave the result untouched.
        for (int j = 0; j < NJ; j++) delta[j] = W'($urandom);
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        tick();
        chk("hold_done", done, 1);
        chk("hold_iter", iter_count, m_iter);
        chk("hold_conv", converged, m_small);
        cmp_dh("hold");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        int  sel;
        vec_t v;

        rst        = 1'b0;
        start      = 1'b0;
        solve_done = 1'b0;
        dh_init    = '0;
        joint_type = '0;
        lim_lo     = '0;
        lim_hi     = '0;
        eps        = '0;
        max_iter   = 8'd0;
        delta      = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_solve_en", solve_en, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_dh_any", longint'(|dh_param), 0);
        rst = 1'b1;
        tick();

        //                 jnt pr  sv        lo      hi        dlt   odlt eps   mi  exp_val iter conv pulses
        vt.push_back('{0, 1'b0, 50,       -1000,  1000,     0,    0,   1,    5,  50,     1, 1'b1, 1});
        vt.push_back('{2, 1'b0, 100,      -1000,  1000,     5,    0,   1,    1,  105,    1, 1'b0, 1});
        vt.push_back('{4, 1'b1, 90,       0,      95,       20,   0,   1,    1,  95,     1, 1'b0, 1});
        vt.push_back('{1, 1'b0, SMAX - 9, 0,      SMAX,     100,  0,   1,    1,  SMAX,   1, 1'b0, 1});
        vt.push_back('{3, 1'b0, 0,        -1000000, 1000000, 50,  50,  1,    3,  150,    3, 1'b0, 3});
        vt.push_back('{5, 1'b0, 7,        10,     -10,      0,    0,   1,    4,  10,     1, 1'b1, 1});
        vt.push_back('{0, 1'b0, 20,       -1000,  1000,     3,    0,   1,    0,  23,     1, 1'b0, 1});
        vt.push_back('{2, 1'b1, SMIN + 5, SMIN,   0,        -100, 0,   1,    1,  SMIN,   1, 1'b0, 1});
        vt.push_back('{1, 1'b0, 10,       -1000,  1000,     4,    0,   4,    2,  18,     2, 1'b0, 2});
        vt.push_back('{1, 1'b1, 10,       -1000,  1000,     4,    0,   5,    2,  14,     1, 1'b1, 1});
        vt.push_back('{0, 1'b0, 0,        -1000,  1000,     SMIN, 0,   SMAX, 1,  -1000,  1, 1'b0, 1});

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            setup_base();
            m_jt[v.jnt] = v.prism;
            sel = v.prism ? DD : TH;
            m_dh[v.jnt][sel] = v.sv;
            m_lo[v.jnt] = v.lo;
            m_hi[v.jnt] = v.hi;
            m_eps  = v.eps;
            m_mi   = v.mi;
            g_mode = 0;
            g_jnt  = v.jnt;
            g_dlt  = v.dlt;
            g_odlt = v.odlt;
            run(1'b0, p);
            chk($sformatf("vec%0d_val", i), sx(dh_param[v.jnt][sel]), v.exp_val);
            chk($sformatf("vec%0d_iter", i), iter_count, v.exp_iter);
            chk($sformatf("vec%0d_conv", i), converged, v.exp_conv);
            chk($sformatf("vec%0d_pulses", i), p, v.exp_pulses);
        end

        for (int r = 0; r < 8; r++) begin
            setup_base();
            for (int j = 0; j < NJ; j++) begin
                m_jt[j]     = bit'($urandom_range(0, 1));
                m_dh[j][TH] = longint'($urandom_range(0, 10000)) - 5000;
                m_dh[j][DD] = longint'($urandom_range(0, 10000)) - 5000;
                m_dh[j][AA] = longint'($signed($urandom));
                m_dh[j][AL] = longint'($signed($urandom));
                m_lo[j]     = -longint'($urandom_range(0, 3000));
                m_hi[j]     = longint'($urandom_range(0, 3000));
                if ($urandom_range(0, 7) == 0) begin
                    m_lo[j] = 500;
                    m_hi[j] = -500;
                end
            end
            m_eps  = longint'($urandom_range(1, 40));
            m_mi   = int'($urandom_range(0, 6));
            g_mode = 1;
            run(1'b1, p);
        end

        // Reset in the middle of the update sweep, then a fresh solve.
        setup_base();
        m_eps  = 1;
        m_mi   = 5;
        g_mode = 2;
        g_jnt  = 0;
        g_dlt  = 7;
        g_odlt = 7;
        drive_cfg();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !solve_en; i++) tick();
        chk("rstseq_solve_en", solve_en, 1);
        gen_delta(0);
        for (int j = 0; j < NJ; j++) delta[j] = W'(cur_d[j]);
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        tick();
        tick();
        tick();
        chk("rstseq_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstseq_dh_any", longint'(|dh_param), 0);
        chk("rstseq_busy", busy, 0);
        chk("rstseq_done", done, 0);
        chk("rstseq_conv", converged, 0);
        chk("rstseq_iter", iter_count, 0);
        chk("rstseq_solve_en0", solve_en, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_dh_any", longint'(|dh_param), 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_solve_en", solve_en, 0);
        chk("post_rst_done", done, 0);
        setup_base();
        run(1'b0, p);
        chk("fresh_pulses", p, 5);
        chk("fresh_theta0", sx(dh_param[0][TH]), 11 + 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
